// File: rtl/mux_debounce_pkg.sv
// -----------------------------------------------------------------------------
// mux_debounce_pkg
// Shared definitions for the 4-to-1 debounced input mux:
//   - state_t     : debounce FSM state (STABLE, SETTLING)
//   - SEL_DATA0..3: encoding of {i_sel1, i_sel0} onto the four data lines
// -----------------------------------------------------------------------------
package mux_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam logic [1:0] SEL_DATA0 = 2'b00;
    localparam logic [1:0] SEL_DATA1 = 2'b01;
    localparam logic [1:0] SEL_DATA2 = 2'b10;
    localparam logic [1:0] SEL_DATA3 = 2'b11;

endpackage

// File: rtl/mux_debounce_4_to_1_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchroniser for an asynchronous input.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset, clears both flops to 0
//   i_async - asynchronous input bit
//   o_sync  - synchronised output (2 clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first flop may go metastable, the second resolves it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/mux_debounce_4_to_1.sv
// -----------------------------------------------------------------------------
// mux_debounce_4_to_1
// Selects one of four asynchronous board inputs with a 2-bit select and
// presents it as a debounced level, with optional one-cycle edge pulses.
//
// Parameters:
//   DEBOUNCE_LIMIT - stable clocks required before o_data follows (>= 2)
// Ports:
//   i_clk             - system clock
//   i_rst_n           - asynchronous active-low reset
//   i_data0..i_data3  - asynchronous data lines
//   i_sel0, i_sel1    - asynchronous select, {i_sel1,i_sel0} picks the line
//   o_data            - debounced level of the selected line (registered)
//   o_rise / o_fall   - one-cycle pulse when o_data goes 0->1 / 1->0
// Build option:
//   MUX_EDGE_DETECT_EN - when defined, o_rise/o_fall are generated; when
//                        undefined they are tied to 0. o_data is unaffected.
// -----------------------------------------------------------------------------
module mux_debounce_4_to_1
    import mux_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_data0,
    input  logic i_data1,
    input  logic i_data2,
    input  logic i_data3,
    input  logic i_sel0,
    input  logic i_sel1,
    output logic o_data,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};

    // Bits [3:0] are the data lines, [5:4] the select.
    logic [5:0] async_in_s;
    logic [5:0] sync_s;
    logic [3:0] data_s;
    logic [1:0] sel_s;
    logic       sample_s;
    logic       mismatch_s;
    logic       sel_chg_s;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             data_q,     data_d;
    logic [1:0]       sel_prev_q;

    assign async_in_s = {i_sel1, i_sel0, i_data3, i_data2, i_data1, i_data0};

    for (genvar g = 0; g < 6; g++) begin : g_sync
        sync_2ff u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (async_in_s[g]),
            .o_sync  (sync_s[g])
        );
    end

    assign data_s     = sync_s[3:0];
    assign sel_s      = sync_s[5:4];
    assign mismatch_s = (sample_s != data_q);
    assign sel_chg_s  = (sel_s != sel_prev_q);

    // Route the synchronised line chosen by the synchronised select.
    always_comb begin
        sample_s = data_s[0];
        case (sel_s)
            SEL_DATA0: sample_s = data_s[0];
            SEL_DATA1: sample_s = data_s[1];
            SEL_DATA2: sample_s = data_s[2];
            SEL_DATA3: sample_s = data_s[3];
            default:   sample_s = data_s[0];
        endcase
    end

    // Debounce next-state: a select change restarts qualification from scratch,
    // otherwise the sample must disagree with o_data for LIMIT+1 straight clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (sel_chg_s) begin
            cnt_d = CNT_ZERO;
            if (mismatch_s) begin
                state_d = SETTLING;
            end else begin
                state_d = STABLE;
            end
        end else begin
            case (state_q)
                STABLE: begin
                    if (mismatch_s) begin
                        state_d = SETTLING;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = STABLE;
                    end
                end
                SETTLING: begin
                    if (!mismatch_s) begin
                        // Glitch rejected.
                        state_d = STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_MAX) begin
                        data_d  = sample_s;
                        state_d = STABLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM, counter, output level and previous-select registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= STABLE;
            cnt_q      <= CNT_ZERO;
            data_q     <= 1'b0;
            sel_prev_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sel_prev_q <= sel_s;
        end
    end

    assign o_data = data_q;

`ifdef MUX_EDGE_DETECT_EN
    logic rise_q;
    logic fall_q;

    // Pulses are registered alongside data_q so they line up with the level change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (data_d != data_q) &  data_d;
            fall_q <= (data_d != data_q) & ~data_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_mux_debounce_4_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_debounce_4_to_1
// Directed bench for mux_debounce_4_to_1 with DEBOUNCE_LIMIT = 8. A behavioural
// model (pin history + run-length of disagreement) is checked against the DUT
// every cycle, and hand-computed latencies pin the model at the key points.
// Works in both builds (MUX_EDGE_DETECT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_mux_debounce_4_to_1;

    localparam int LIMIT = 8;
`ifdef MUX_EDGE_DETECT_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic d0, d1, d2, d3;
    logic sel0, sel1;
    logic o_data, o_rise, o_fall;

    int checks = 0;
    int errors = 0;

    mux_debounce_4_to_1 #(.DEBOUNCE_LIMIT(LIMIT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data0 (d0),
        .i_data1 (d1),
        .i_data2 (d2),
        .i_data3 (d3),
        .i_sel0  (sel0),
        .i_sel1  (sel1),
        .o_data  (o_data),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // p1/p2: pins as captured one and two edges ago ({sel1,sel0,d3..d0}).
    // run:   consecutive edges the selected synced line has disagreed with the
    //        output under an unchanged select; LIMIT+1 of them commits.
    logic [5:0] p1, p2, cur;
    logic [1:0] m_prev_sel, m_sel;
    logic       m_smp, m_data, m_rise, m_fall;
    int         m_run;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                p1 = 6'd0; p2 = 6'd0; m_prev_sel = 2'd0; m_run = 0;
                m_data = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            end else begin
                cur    = p2;
                m_sel  = cur[5:4];
                m_smp  = cur[m_sel];
                m_rise = 1'b0;
                m_fall = 1'b0;
                if (m_sel != m_prev_sel) begin
                    m_run = (m_smp != m_data) ? 1 : 0;
                end else if (m_smp == m_data) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == LIMIT + 1) begin
                        m_rise = EDGE_EN & m_smp;
                        m_fall = EDGE_EN & ~m_smp;
                        m_data = m_smp;
                        m_run  = 0;
                    end
                end
                m_prev_sel = m_sel;
                p2 = p1;
                p1 = {sel1, sel0, d3, d2, d1, d0};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_data", o_data, m_data);
            check("cyc_rise", o_rise, m_rise);
            check("cyc_fall", o_fall, m_fall);
            check("cyc_excl", o_rise & o_fall, 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_edges(3);
        check("reset_data", o_data, 1'b0);
        check("reset_rise", o_rise, 1'b0);
        check("reset_fall", o_fall, 1'b0);

        // Rise on data0: visible exactly 11 edges after the pin edge.
        @(negedge clk); d0 = 1'b1;
        wait_edges(10);
        check("rise_early", o_data, 1'b0);
        wait_edges(1);
        check("rise_data", o_data, 1'b1);
        check("rise_pulse", o_rise, EDGE_EN);
        check("rise_nofall", o_fall, 1'b0);
        wait_edges(1);
        check("rise_once", o_rise, 1'b0);
        check("rise_hold", o_data, 1'b1);

        // Fall on data0.
        wait_edges(3);
        @(negedge clk); d0 = 1'b0;
        wait_edges(10);
        check("fall_early", o_data, 1'b1);
        wait_edges(1);
        check("fall_data", o_data, 1'b0);
        check("fall_pulse", o_fall, EDGE_EN);
        check("fall_norise", o_rise, 1'b0);
        wait_edges(1);
        check("fall_once", o_fall, 1'b0);

        // Glitch of 5 clocks is rejected.
        wait_edges(3);
        @(negedge clk); d0 = 1'b1;
        repeat (5) @(negedge clk);
        d0 = 1'b0;
        wait_edges(20);
        check("glitch_data", o_data, 1'b0);

        // Unselected data2 high has no effect; then select it while data1 toggles.
        @(negedge clk); d2 = 1'b1;
        wait_edges(5);
        check("unsel_data", o_data, 1'b0);
        @(negedge clk); sel1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) check("selsw_early", o_data, 1'b0);
            if (i == 11) begin
                check("selsw_data", o_data, 1'b1);
                check("selsw_rise", o_rise, EDGE_EN);
            end
            if (i == 12) check("selsw_once", o_rise, 1'b0);
            @(negedge clk); d1 = ~d1;
        end

        // Bring output back to 0 on sel=00 before the mid-settling switch.
        @(negedge clk); d1 = 1'b0; d2 = 1'b0;
        wait_edges(15);
        check("prep_low", o_data, 1'b0);
        @(negedge clk); sel1 = 1'b0;
        wait_edges(5);
        @(negedge clk); d0 = 1'b1;
        repeat (4) @(negedge clk);
        sel0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            check("midsw_data", o_data, 1'b0);
            check("midsw_rise", o_rise, 1'b0);
        end

        // Reset asserted mid-settling while o_data is 1.
        @(negedge clk); sel0 = 1'b0;
        wait_edges(15);
        check("rst_pre_high", o_data, 1'b1);
        @(negedge clk); d0 = 1'b0;
        wait_edges(5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data", o_data, 1'b0);
        check("rst_async_rise", o_rise, 1'b0);
        check("rst_async_fall", o_fall, 1'b0);
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wait_edges(15);
        check("rst_rel_data", o_data, 1'b0);
        check("rst_rel_rise", o_rise, 1'b0);

        // Selected input already high when reset releases qualifies normally.
        @(negedge clk); rst_n = 1'b0; d0 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        wait_edges(10);
        check("postrst_early", o_data, 1'b0);
        wait_edges(1);
        check("postrst_data", o_data, 1'b1);
        check("postrst_rise", o_rise, EDGE_EN);

        wait_edges(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
